// File: rtl/mux_sync_tx.sv
// Source-side transmitter of a mux-synchronizer crossing: holds an accepted word
// on a registered bus while a four-phase req/ack handshake runs with the destination.
module mux_sync_tx #(
  parameter int DSIZE       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [DSIZE-1:0] data_out,
  output logic             enable,
  input  logic             ack,
  output logic             done,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_s;
  logic                   ack_s_d_r;
  logic [DSIZE-1:0]       data_r;
  logic                   enable_r;
  logic                   done_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   err_r;
  logic                   accept_s;
  logic                   ack_taken_s;
  logic                   ack_rise_s;

  // ack synchronizer chain plus the delayed copy used for rise detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
      ack_s_d_r  <= 1'b0;
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack};
      ack_s_d_r  <= ack_s;
    end
  end

  assign ack_s       = ack_sync_r[SYNC_STAGES-1];
  assign accept_s    = (state_r == IDLE) & src_valid;
  assign ack_taken_s = (state_r == REQ) & ack_s;
  assign ack_rise_s  = ack_s & ~ack_s_d_r;

  // next-state decode of the four-phase handshake
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (src_valid) state_nxt_s = REQ;
        else           state_nxt_s = IDLE;
      end
      REQ: begin
        if (ack_s) state_nxt_s = RELEASE;
        else       state_nxt_s = REQ;
      end
      RELEASE: begin
        if (!ack_s) state_nxt_s = IDLE;
        else        state_nxt_s = RELEASE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // state register and registered outputs; data only loads on an IDLE accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      data_r   <= {DSIZE{1'b0}};
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      enable_r <= (state_nxt_s == REQ);
      done_r   <= ack_taken_s;
      if (accept_s) begin
        data_r <= src_data;
      end
      if (ack_taken_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // an ack rising while no request is outstanding is a destination fault
      if ((state_r == IDLE) && ack_rise_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign src_ready = (state_r == IDLE);
  assign data_out  = data_r;
  assign enable    = enable_r;
  assign done      = done_r;
  assign xfer_cnt  = cnt_r;
  assign proto_err = err_r;

endmodule

// File: doc/mux_sync_tx.md
Name: mux_sync_tx

Overview:
- Source-domain transmitter for the mux-synchronizer crossing. It accepts one word at a time from a local producer over a valid/ready handshake.
- The accepted word is held stable on a registered data bus while a level request (enable) goes to the destination domain.
- A four-phase handshake with an acknowledge returned from the destination (req up, ack up, req down, ack down) guarantees the data bus never changes while the receiver may sample it.

Parameters:
- DSIZE, 32, width of the transferred data word.
- SYNC_STAGES, 2, number of flops in the ack synchronizer chain; legal range 2..4.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  source-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- src_data  input  DSIZE  word from the local producer.
- src_valid  input  1  producer has a word on src_data.
- src_ready  output  1  block can accept a word this cycle.
- data_out  output  DSIZE  held word driven across the crossing.
- enable  output  1  request level to the destination; registered.
- ack  input  1  acknowledge from the destination domain; asynchronous to clk.
- done  output  1  one-cycle pulse when the destination has acknowledged a word.
- xfer_cnt  output  CNT_W  count of completed transfers; wraps.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset: one clock, asynchronous active-low reset (rst_n); every flop resets asynchronously.
- Reset values: state=IDLE, data_out=0, enable=0, done=0, xfer_cnt=0, proto_err=0, all ack synchronizer flops=0. src_ready=1 combinationally from IDLE.
- ack path: ack is synchronized through SYNC_STAGES flops. Call the last stage ack_s. Only ack_s is used in logic, and ack_s_d is its one-cycle delayed copy.
- src_ready = (state==IDLE); purely a state decode, no combinational path from src_valid.
- FSM states: IDLE, REQ, RELEASE.
- IDLE: if src_valid at edge N, then at N+1 data_out=src_data, enable=1, state=REQ. Accept-to-enable latency is 1 cycle, and data and enable update on the same edge. Otherwise hold.
- REQ: enable=1. When ack_s==1, the next edge sets enable=0, state=RELEASE, done=1 for that one cycle, and xfer_cnt+1 (modulo 2^CNT_W, all-ones wraps to 0).
- RELEASE: enable=0. When ack_s==0, the next edge sets state=IDLE, and src_ready is high that cycle.
- Minimum turnaround per word: 2*(SYNC_STAGES+1) source cycles plus the destination's delay.
- data_out changes only on an accepted IDLE transfer. It is stable throughout REQ and RELEASE, and retains its value in IDLE after completion.
- src_valid or src_data changes outside IDLE are ignored; no buffering, no drop flag.
- proto_err is set (sticky until reset) when ack_s rises (ack_s & ~ack_s_d) while state==IDLE.
- ack_s already high on entry to REQ (stale ack) is accepted as an ack. proto_err flags the earlier rise.
- Simultaneous events: done and a new src_valid cannot coincide because src_ready=0 outside IDLE. Reset overrides everything.
- Reset mid-transfer: enable drops immediately (async) and data_out clears to 0. The block restarts in IDLE. A destination still holding ack high after reset trips proto_err only on a fresh rising edge of ack_s.

Test Plan:
- Reset, then src_valid=1 with src_data=0xDEADBEEF at cycle 5: cycle 6 gives data_out=0xDEADBEEF, enable=1, src_ready=0. ack driven high at cycle 10: done=1 at cycle 13, enable=0. ack low at cycle 15: src_ready=1 at cycle 18, xfer_cnt=1.
- Back-to-back words 0x1, 0x2, 0x3 with src_valid held high and an ack responder delaying 3 cycles: exactly 3 done pulses, xfer_cnt=3. data_out never changes while enable=1 or in RELEASE.
- While in REQ, toggle src_data every cycle (0xAAAA5555/0x5555AAAA): data_out holds the first accepted value until the next IDLE accept.
- ack pulse while IDLE: proto_err=1 at SYNC_STAGES+1 cycles later and stays 1 through further clean transfers until rst_n=0.
- Assert rst_n=0 asynchronously while in REQ: enable=0, data_out=0, xfer_cnt=0 before the next clk edge. After release, src_ready=1.
- CNT_W=4, run 17 transfers: xfer_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
